dp_issue: RTL and testbench
===========================

# dp_issue

Sequential issue and writeback controller for data-processing instructions. It accepts a 32-bit instruction word over a valid/ready handshake, decodes it, and evaluates the condition code against the NZCV flags. It then reads Rn and Rm from the register file and drives the shared operand bus of the per-opcode op units (XOR, AND, ADD, …) with a one-hot enable whose rising edge launches the unit. Finally it captures the returned result and flags, writes Rd back to the register file, and updates NZCV.

## Interface
- `RESULT_LAT`, default 1: cycles between the enable rising edge and sampling of the op-unit result; range 1–15.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: instruction word present.
- `in_instr` in 32: instruction word.
- `in_ready` out 1: block can accept an instruction; high only in IDLE.
- `rf_raddr_a`, `rf_raddr_b` out 4: register-file read addresses for Rn and Rm.
- `rf_rdata_a`, `rf_rdata_b` in 32: combinational read data for those addresses.
- `rf_we` out 1: one-cycle writeback strobe.
- `rf_waddr` out 4: writeback register number.
- `rf_wdata` out 32: writeback data.
- `en_op` out 16: one-hot op-unit enable; the bit index equals the opcode.
- `op_imm`, `op_s` out 1: immediate-form flag and S bit.
- `op_rn`, `op_rm` out 32: operand values.
- `op_imm_operand` out 12: immediate operand.
- `op_imm_shift` out 5: shift amount.
- `op_stype` out 2: shift type.
- `op_carry_in`, `op_zero_in`, `op_neg_in` out 1: current C, Z and N flags.
- `op_rd` in 32: selected op-unit result.
- `op_carry`, `op_zero`, `op_neg` in 1: flags returned by the selected op unit.
- `flags` out 4: NZCV, with N in bit 3.
- `skipped` out 1: one-cycle pulse when the condition check fails.
- `err` out 1: one-cycle pulse when the encoding is undefined.

## Operation
- Decode fields:
  - [31:28] cond; [27:26] must be 00; [25] I; [24:21] opcode; [20] S; [19:16] Rn; [15:12] Rd.
  - I=1: [11:0] is the 12-bit immediate, zero-extended by the op unit with no rotation.
  - I=0: [11:7] imm5, [6:5] stype, [4] must be 0, [3:0] Rm.
- Undefined encodings raise `err` and the instruction is dropped. These are:
  - [27:26] ≠ 00;
  - I=0 with bit 4 = 1;
  - cond = 1111;
  - Rd = 15 on an opcode that writes Rd.
- Condition codes follow the standard EQ…AL table (0000–1110) over the `flags` register.
- Opcodes 8–11 (TST/TEQ/CMP/CMN) never write Rd. They always update flags, whatever the S bit says.
- Flag update, performed in WB only:
  - If S=1 (or the opcode is a compare), N, Z and C are loaded from `op_neg`, `op_zero` and `op_carry`.
  - V is never modified by this block.
  - If S=0, flags are unchanged.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, latch the word and go to READ.
  - READ: drive the Rn/Rm addresses and latch the operands into the `op_*` registers. If undefined, go to IDLE and pulse `err`. If the condition fails, go to IDLE and pulse `skipped`. Otherwise go to ISSUE.
  - ISSUE: raise `en_op[opcode]`; load the wait counter with `RESULT_LAT`-1; go to WAIT.
  - WAIT: hold `en_op`; decrement the counter. When the counter is 0, sample `op_*` results and go to WB.
  - WB: `en_op`=0; pulse `rf_we` (when the opcode writes Rd) with the sampled result; update flags; go to IDLE.
- `en_op` is low in IDLE, READ and WB, so every issued instruction produces a fresh rising edge.
- All `op_*` operand outputs are registered and stable from ISSUE through WB.

## Timing
- Accept handshake at cycle 0 (`in_valid`=1 and `in_ready`=1). READ is cycle 1, ISSUE is cycle 2, WAIT covers cycles 3 to 2+`RESULT_LAT`, and WB is cycle 3+`RESULT_LAT`.
- `in_ready` returns high the cycle after WB, after `skipped`, or after `err`. With `RESULT_LAT`=1, throughput is one instruction per 5 cycles.
- `skipped` and `err` are asserted in cycle 2, and `in_ready`=1 in that same cycle.
- Reset values:
  - `in_ready`=1;
  - every other output = 0, including `en_op`, `rf_we`, `skipped` and `err`;
  - `flags` = 0000;
  - state = IDLE.
- Reset asserted mid-operation aborts the instruction immediately: no `rf_we`, no flag update, and `en_op` drops asynchronously.
- `in_valid` is ignored while `in_ready`=0, and `in_instr` is not sampled then.

## Structure
- Package `dp_defs`: opcode localparams (AND…MVN, 0–15), condition-code localparams, shift-type localparams, FSM state encoding, and the flag-bit indices `N_BIT`/`Z_BIT`/`C_BIT`/`V_BIT`.
- Sub-module `cond_check`: combinational; inputs cond[3:0] and NZCV; output `pass`.

## Test plan
- EOR immediate: r1=0x0000_00F0, `in_instr`=0xE23120FF, `RESULT_LAT`=1.
  - Required: `en_op[1]` rises in cycle 2 with `op_imm`=1, `op_imm_operand`=0x0FF, `op_rn`=0xF0.
  - With `op_rd`=0x0000_000F returned, cycle 4 shows `rf_we`=1, `rf_waddr`=2, `rf_wdata`=0x0000_000F, and `flags`=0000.
- Register form with shift: `in_instr`=0xE0312223 (EOR r2,r1,r3,LSR #4), r3=0xFFFF_0000.
  - Required: `op_imm`=0, `op_imm_shift`=4, `op_stype`=01, `op_rm`=0xFFFF_0000.
- Condition fail: Z=0, `in_instr`=0x023120FF (EQ).
  - Required: `skipped` in cycle 2; no `en_op`, no `rf_we`; flags unchanged.
- TEQ versus S=0:
  - 0xE1310002 with `op_zero`=1 returned: Z set, no `rf_we`.
  - 0xE0212003 (EOR, S=0): `rf_we`=1 and `flags` unchanged.
- Undefined encoding: 0xE0312213 (bit 4 = 1).
  - Required: `err` in cycle 2; `en_op` stays 0; `in_ready`=1 in cycle 2.
- Reset mid-operation: `RESULT_LAT`=4, assert `rst` during WAIT.
  - Required: `en_op`=0 immediately and no `rf_we`.
  - After release: `flags`=0000, `in_ready`=1, and the next instruction completes normally.

Source files
------------

// File: rtl/dp_issue_pkg.sv
// Shared definitions for the data-processing issue controller: opcodes,
// condition codes, shift types, flag-bit positions and FSM encoding.
package dp_defs;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_EOR = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_RSB = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_ADC = 4'd5;
    localparam logic [3:0] OP_SBC = 4'd6;
    localparam logic [3:0] OP_RSC = 4'd7;
    localparam logic [3:0] OP_TST = 4'd8;
    localparam logic [3:0] OP_TEQ = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;
    localparam logic [3:0] OP_CMN = 4'd11;
    localparam logic [3:0] OP_ORR = 4'd12;
    localparam logic [3:0] OP_MOV = 4'd13;
    localparam logic [3:0] OP_BIC = 4'd14;
    localparam logic [3:0] OP_MVN = 4'd15;

    localparam logic [3:0] CC_EQ = 4'd0;
    localparam logic [3:0] CC_NE = 4'd1;
    localparam logic [3:0] CC_CS = 4'd2;
    localparam logic [3:0] CC_CC = 4'd3;
    localparam logic [3:0] CC_MI = 4'd4;
    localparam logic [3:0] CC_PL = 4'd5;
    localparam logic [3:0] CC_VS = 4'd6;
    localparam logic [3:0] CC_VC = 4'd7;
    localparam logic [3:0] CC_HI = 4'd8;
    localparam logic [3:0] CC_LS = 4'd9;
    localparam logic [3:0] CC_GE = 4'd10;
    localparam logic [3:0] CC_LT = 4'd11;
    localparam logic [3:0] CC_GT = 4'd12;
    localparam logic [3:0] CC_LE = 4'd13;
    localparam logic [3:0] CC_AL = 4'd14;
    localparam logic [3:0] CC_NV = 4'd15;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_ISSUE,
        ST_WAIT,
        ST_WB
    } state_t;

    // TST/TEQ/CMP/CMN occupy 8..11 and only produce flags.
    function automatic logic writes_rd(input logic [3:0] opc);
        return opc[3:2] != 2'b10;
    endfunction

endpackage

// File: rtl/dp_issue_if.sv
// Instruction handshake, register-file ports and op-unit bus of dp_issue.
interface dp_issue_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic [3:0]  rf_raddr_a;
    logic [3:0]  rf_raddr_b;
    logic [31:0] rf_rdata_a;
    logic [31:0] rf_rdata_b;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] en_op;
    logic        op_imm;
    logic        op_s;
    logic [31:0] op_rn;
    logic [31:0] op_rm;
    logic [11:0] op_imm_operand;
    logic [4:0]  op_imm_shift;
    logic [1:0]  op_stype;
    logic        op_carry_in;
    logic        op_zero_in;
    logic        op_neg_in;
    logic [31:0] op_rd;
    logic        op_carry;
    logic        op_zero;
    logic        op_neg;
    logic [3:0]  flags;
    logic        skipped;
    logic        err;

    modport slave (
        input  in_valid, in_instr, rf_rdata_a, rf_rdata_b,
               op_rd, op_carry, op_zero, op_neg,
        output in_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               en_op, op_imm, op_s, op_rn, op_rm, op_imm_operand,
               op_imm_shift, op_stype, op_carry_in, op_zero_in, op_neg_in,
               flags, skipped, err
    );

    modport master (
        output in_valid, in_instr, rf_rdata_a, rf_rdata_b,
               op_rd, op_carry, op_zero, op_neg,
        input  in_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               en_op, op_imm, op_s, op_rn, op_rm, op_imm_operand,
               op_imm_shift, op_stype, op_carry_in, op_zero_in, op_neg_in,
               flags, skipped, err
    );
endinterface

// File: rtl/dp_issue_cond_check.sv
// Condition-code evaluation over NZCV; cond 1111 never passes.
module cond_check
    import dp_defs::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);
    logic n, z, c, v;

    assign n = nzcv[N_BIT];
    assign z = nzcv[Z_BIT];
    assign c = nzcv[C_BIT];
    assign v = nzcv[V_BIT];

    always_comb begin
        pass = 1'b0;
        case (cond)
            CC_EQ: pass = z;
            CC_NE: pass = ~z;
            CC_CS: pass = c;
            CC_CC: pass = ~c;
            CC_MI: pass = n;
            CC_PL: pass = ~n;
            CC_VS: pass = v;
            CC_VC: pass = ~v;
            CC_HI: pass = c & ~z;
            CC_LS: pass = ~c | z;
            CC_GE: pass = (n == v);
            CC_LT: pass = (n != v);
            CC_GT: pass = ~z & (n == v);
            CC_LE: pass = z | (n != v);
            CC_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/dp_issue.sv
// Sequential issue/writeback controller: decode, condition check, operand
// read, op-unit launch, result wait and Rd/NZCV writeback.
module dp_issue
    import dp_defs::*;
#(
    parameter int RESULT_LAT = 1
) (
    input logic       clk,
    input logic       rst,
    dp_issue_if.slave bus
);
    state_t      st;
    logic [31:0] ir;
    logic [3:0]  cnt;
    logic [3:0]  opc;
    logic        wr, upd, undef, pass;

    assign opc = ir[24:21];
    assign wr  = writes_rd(opc);
    assign upd = ir[20] | ~wr;
    assign undef = (ir[27:26] != 2'b00) | (~ir[25] & ir[4]) |
                   (ir[31:28] == CC_NV) | (wr & (ir[15:12] == 4'hF));

    // Addresses come straight from the latched word; read data is combinational.
    assign bus.rf_raddr_a = ir[19:16];
    assign bus.rf_raddr_b = ir[3:0];

    cond_check u_cond (
        .cond (ir[31:28]),
        .nzcv (bus.flags),
        .pass (pass)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st                 <= ST_IDLE;
            ir                 <= '0;
            cnt                <= '0;
            bus.in_ready       <= 1'b1;
            bus.rf_we          <= 1'b0;
            bus.rf_waddr       <= '0;
            bus.rf_wdata       <= '0;
            bus.en_op          <= '0;
            bus.op_imm         <= 1'b0;
            bus.op_s           <= 1'b0;
            bus.op_rn          <= '0;
            bus.op_rm          <= '0;
            bus.op_imm_operand <= '0;
            bus.op_imm_shift   <= '0;
            bus.op_stype       <= '0;
            bus.op_carry_in    <= 1'b0;
            bus.op_zero_in     <= 1'b0;
            bus.op_neg_in      <= 1'b0;
            bus.flags          <= '0;
            bus.skipped        <= 1'b0;
            bus.err            <= 1'b0;
        end else begin
            bus.rf_we   <= 1'b0;
            bus.skipped <= 1'b0;
            bus.err     <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        ir           <= bus.in_instr;
                        bus.in_ready <= 1'b0;
                        st           <= ST_READ;
                    end
                end
                ST_READ: begin
                    bus.op_imm         <= ir[25];
                    bus.op_s           <= ir[20];
                    bus.op_rn          <= bus.rf_rdata_a;
                    bus.op_rm          <= bus.rf_rdata_b;
                    bus.op_imm_operand <= ir[11:0];
                    bus.op_imm_shift   <= ir[11:7];
                    bus.op_stype       <= ir[6:5];
                    bus.op_carry_in    <= bus.flags[C_BIT];
                    bus.op_zero_in     <= bus.flags[Z_BIT];
                    bus.op_neg_in      <= bus.flags[N_BIT];
                    bus.rf_waddr       <= ir[15:12];
                    if (undef) begin
                        bus.err      <= 1'b1;
                        bus.in_ready <= 1'b1;
                        st           <= ST_IDLE;
                    end else if (!pass) begin
                        bus.skipped  <= 1'b1;
                        bus.in_ready <= 1'b1;
                        st           <= ST_IDLE;
                    end else begin
                        bus.en_op <= 16'b1 << opc;
                        st        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt <= 4'(RESULT_LAT - 1);
                    st  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        // Results land in WB together with the strobe and flag update.
                        bus.en_op    <= '0;
                        bus.rf_we    <= wr;
                        bus.rf_wdata <= bus.op_rd;
                        if (upd) begin
                            bus.flags[N_BIT] <= bus.op_neg;
                            bus.flags[Z_BIT] <= bus.op_zero;
                            bus.flags[C_BIT] <= bus.op_carry;
                        end
                        st <= ST_WB;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_WB: begin
                    bus.in_ready <= 1'b1;
                    st           <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dp_issue.sv
// Bench for dp_issue: instruction-level model checked every cycle, literal
// pins on the key cycles, and a reset-abort scenario on a RESULT_LAT=4 copy.
module tb_dp_issue;
    localparam int WBP = 4;   // WB phase with RESULT_LAT=1

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst4 = 1'b1;
    always #5 clk = ~clk;

    dp_issue_if bus ();
    dp_issue_if bus4 ();

    dp_issue #(.RESULT_LAT(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    dp_issue #(.RESULT_LAT(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));

    logic [31:0] rf [16];
    logic [31:0] ret_rd = 32'h0;
    logic ret_n = 1'b0, ret_z = 1'b0, ret_c = 1'b0;

    assign bus.rf_rdata_a  = rf[bus.rf_raddr_a];
    assign bus.rf_rdata_b  = rf[bus.rf_raddr_b];
    assign bus.op_rd       = ret_rd;
    assign bus.op_neg      = ret_n;
    assign bus.op_zero     = ret_z;
    assign bus.op_carry    = ret_c;
    assign bus4.rf_rdata_a = rf[bus4.rf_raddr_a];
    assign bus4.rf_rdata_b = rf[bus4.rf_raddr_b];
    assign bus4.op_rd      = ret_rd;
    assign bus4.op_neg     = ret_n;
    assign bus4.op_zero    = ret_z;
    assign bus4.op_carry   = ret_c;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    // kind: 0 executes, 1 condition fails, 2 undefined
    typedef struct {
        int          kind;
        logic [15:0] en;
        logic        imm, s;
        logic [31:0] rn, rm;
        logic [11:0] immv;
        logic [4:0]  sh;
        logic [1:0]  st;
        logic [3:0]  f0;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  nf;
    } exp_t;

    function automatic exp_t model(input logic [31:0] w, input logic [3:0] f);
        exp_t e;
        logic [3:0] cond, opc;
        logic [7:0] tbl;
        logic base, pass, cmp, und;
        cond = w[31:28];
        opc  = w[24:21];
        cmp  = (opc >= 4'd8) && (opc <= 4'd11);
        // Even codes test a predicate, odd codes its inverse; 1110 always.
        tbl  = {1'b1, ~f[2] & (f[3] == f[0]), f[3] == f[0], f[1] & ~f[2],
                f[0], f[3], f[1], f[2]};
        base = tbl[cond[3:1]];
        pass = (cond == 4'd14) ? 1'b1 : (cond[0] ? ~base : base);
        und  = (w[27:26] != 2'b00) || (!w[25] && w[4]) || (cond == 4'd15) ||
               (!cmp && w[15:12] == 4'd15);
        e.kind = und ? 2 : (pass ? 0 : 1);
        e.en   = 16'h0001 << opc;
        e.imm  = w[25];
        e.s    = w[20];
        e.rn   = rf[w[19:16]];
        e.rm   = rf[w[3:0]];
        e.immv = w[11:0];
        e.sh   = w[11:7];
        e.st   = w[6:5];
        e.f0   = f;
        e.we   = !cmp;
        e.wa   = w[15:12];
        e.wd   = ret_rd;
        e.nf   = (w[20] || cmp) ? {ret_n, ret_z, ret_c, f[0]} : f;
        return e;
    endfunction

    int   ph = -1;
    exp_t e;
    logic [3:0] mf = 4'h0;

    always @(negedge clk) begin : cmp_p
        logic rdy;
        logic run;
        if (rst) begin
            ph = -1;
            mf = 4'h0;
        end else begin
            run = (e.kind == 0) && (ph >= 2);
            if (ph == WBP && e.kind == 0) mf = e.nf;
            rdy = (ph == -1) || (ph == 2 && e.kind != 0);
            chk("in_ready", 32'(bus.in_ready), 32'(rdy));
            chk("flags", 32'(bus.flags), 32'(mf));
            chk("en_op", 32'(bus.en_op), (run && ph < WBP) ? 32'(e.en) : 32'h0);
            chk("rf_we", 32'(bus.rf_we), (run && ph == WBP) ? 32'(e.we) : 32'h0);
            chk("skipped", 32'(bus.skipped), 32'(ph == 2 && e.kind == 1));
            chk("err", 32'(bus.err), 32'(ph == 2 && e.kind == 2));
            if (run && ph == WBP && e.we) begin
                chk("rf_waddr", 32'(bus.rf_waddr), 32'(e.wa));
                chk("rf_wdata", bus.rf_wdata, e.wd);
            end
            if (run && ph <= WBP) begin
                chk("op_imm", 32'(bus.op_imm), 32'(e.imm));
                chk("op_s", 32'(bus.op_s), 32'(e.s));
                chk("op_rn", bus.op_rn, e.rn);
                chk("op_flags_in", 32'({bus.op_neg_in, bus.op_zero_in, bus.op_carry_in}),
                    32'(e.f0[3:1]));
                if (e.imm) chk("op_imm_operand", 32'(bus.op_imm_operand), 32'(e.immv));
                else begin
                    chk("op_rm", bus.op_rm, e.rm);
                    chk("op_imm_shift", 32'(bus.op_imm_shift), 32'(e.sh));
                    chk("op_stype", 32'(bus.op_stype), 32'(e.st));
                end
            end
            if (rdy && bus.in_valid) begin
                e  = model(bus.in_instr, mf);
                ph = 1;
            end else if (ph >= 1) begin
                ph++;
                if (ph > WBP || (e.kind != 0 && ph > 2)) ph = -1;
            end
        end
    end

    task automatic issue(input logic [31:0] w);
        int t;
        t = 0;
        @(posedge clk); #1;
        while (!bus.in_ready && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 40) chk("issue_timeout", 32'(bus.in_ready), 32'h1);
        bus.in_instr = w;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic issue4(input logic [31:0] w);
        int t;
        t = 0;
        @(posedge clk); #1;
        while (!bus4.in_ready && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 40) chk("issue4_timeout", 32'(bus4.in_ready), 32'h1);
        bus4.in_instr = w;
        bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
    endtask

    task automatic set_ret(input logic [31:0] d, input logic n, input logic z, input logic c);
        ret_rd = d;
        ret_n  = n;
        ret_z  = z;
        ret_c  = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'h0;
        rf[1] = 32'h0000_00F0;
        rf[2] = 32'h0000_0A0A;
        rf[3] = 32'hFFFF_0000;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus4.in_valid = 1'b0;
        bus4.in_instr = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_en_op", 32'(bus.en_op), 32'h0);
        chk("rst_rf_we", 32'(bus.rf_we), 32'h0);
        chk("rst_flags", 32'(bus.flags), 32'h0);
        chk("rst_err_skip", 32'({bus.err, bus.skipped}), 32'h0);
        chk("rst_op_rn", bus.op_rn, 32'h0);
        #1 rst = 1'b0;
        rst4 = 1'b0;

        // EOR immediate
        set_ret(32'h0000_000F, 1'b0, 1'b0, 1'b0);
        issue(32'hE23120FF);
        repeat (2) @(negedge clk);
        chk("pin_eor_en", 32'(bus.en_op), 32'h0002);
        chk("pin_eor_imm", 32'(bus.op_imm), 32'h1);
        chk("pin_eor_immv", 32'(bus.op_imm_operand), 32'h0FF);
        chk("pin_eor_rn", bus.op_rn, 32'h0000_00F0);
        repeat (2) @(negedge clk);
        chk("pin_eor_we", 32'(bus.rf_we), 32'h1);
        chk("pin_eor_wa", 32'(bus.rf_waddr), 32'h2);
        chk("pin_eor_wd", bus.rf_wdata, 32'h0000_000F);
        chk("pin_eor_flags", 32'(bus.flags), 32'h0);

        // register form, LSR #4; N returned set
        set_ret(32'hFFFF_00F0, 1'b1, 1'b0, 1'b0);
        issue(32'hE0312223);
        repeat (2) @(negedge clk);
        chk("pin_reg_imm", 32'(bus.op_imm), 32'h0);
        chk("pin_reg_sh", 32'(bus.op_imm_shift), 32'h4);
        chk("pin_reg_st", 32'(bus.op_stype), 32'h1);
        chk("pin_reg_rm", bus.op_rm, 32'hFFFF_0000);
        repeat (2) @(negedge clk);
        chk("pin_reg_flags", 32'(bus.flags), 32'h8);

        // EQ with Z=0 is skipped
        issue(32'h023120FF);
        repeat (2) @(negedge clk);
        chk("pin_skip", 32'(bus.skipped), 32'h1);
        chk("pin_skip_ready", 32'(bus.in_ready), 32'h1);
        chk("pin_skip_en", 32'(bus.en_op), 32'h0);
        @(negedge clk);
        chk("pin_skip_flags", 32'(bus.flags), 32'h8);
        chk("pin_skip_we", 32'(bus.rf_we), 32'h0);

        // TEQ sets Z, no writeback
        set_ret(32'h0, 1'b0, 1'b1, 1'b0);
        issue(32'hE1310002);
        repeat (4) @(negedge clk);
        chk("pin_teq_we", 32'(bus.rf_we), 32'h0);
        chk("pin_teq_flags", 32'(bus.flags), 32'h4);

        // EOR S=0 writes Rd, flags untouched
        set_ret(32'h0000_1234, 1'b1, 1'b0, 1'b1);
        issue(32'hE0212003);
        repeat (4) @(negedge clk);
        chk("pin_nos_we", 32'(bus.rf_we), 32'h1);
        chk("pin_nos_wd", bus.rf_wdata, 32'h0000_1234);
        chk("pin_nos_flags", 32'(bus.flags), 32'h4);

        // register form with bit 4 set is undefined
        issue(32'hE0312213);
        repeat (2) @(negedge clk);
        chk("pin_err", 32'(bus.err), 32'h1);
        chk("pin_err_en", 32'(bus.en_op), 32'h0);
        chk("pin_err_ready", 32'(bus.in_ready), 32'h1);

        // Z=1 now: NE skips, EQ ADD runs
        issue(32'h12812001);
        set_ret(32'h0000_0055, 1'b0, 1'b0, 1'b0);
        issue(32'h02812001);
        repeat (2) @(negedge clk);
        chk("pin_add_en", 32'(bus.en_op), 32'h0010);

        // more undefined encodings
        issue(32'hE231F0FF);
        issue(32'hF23120FF);
        issue(32'hE63120FF);

        // CMP with Rd field 15 is legal
        set_ret(32'h0, 1'b0, 1'b0, 1'b1);
        issue(32'hE151F002);
        repeat (4) @(negedge clk);
        chk("pin_cmp_flags", 32'(bus.flags), 32'h2);
        chk("pin_cmp_we", 32'(bus.rf_we), 32'h0);

        // CS MOVS passes on C=1
        set_ret(32'h0000_0005, 1'b1, 1'b0, 1'b0);
        issue(32'h23B02005);
        repeat (6) @(negedge clk);

        // RESULT_LAT=4: set Z, then abort an instruction in WAIT
        set_ret(32'h0, 1'b0, 1'b1, 1'b0);
        issue4(32'hE1310002);
        repeat (8) @(negedge clk);
        chk("l4_flags_pre", 32'(bus4.flags), 32'h4);
        set_ret(32'h0000_000F, 1'b0, 1'b0, 1'b0);
        issue4(32'hE23120FF);
        repeat (3) @(posedge clk);
        #1;
        chk("l4_en_wait", 32'(bus4.en_op), 32'h0002);
        rst4 = 1'b1;
        #1;
        chk("l4_en_async", 32'(bus4.en_op), 32'h0);
        chk("l4_we_rst", 32'(bus4.rf_we), 32'h0);
        repeat (2) @(negedge clk);
        #1 rst4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("l4_no_we", 32'({bus4.rf_we, bus4.en_op}), 32'h0);
        end
        chk("l4_flags_rst", 32'(bus4.flags), 32'h0);
        chk("l4_ready_rst", 32'(bus4.in_ready), 32'h1);
        set_ret(32'h0000_0055, 1'b0, 1'b0, 1'b0);
        issue4(32'hE2812001);
        @(negedge clk);
        @(negedge clk);
        chk("l4_add_en", 32'(bus4.en_op), 32'h0010);
        repeat (5) @(negedge clk);
        chk("l4_add_we", 32'(bus4.rf_we), 32'h1);
        chk("l4_add_wa", 32'(bus4.rf_waddr), 32'h2);
        chk("l4_add_wd", bus4.rf_wdata, 32'h0000_0055);
        @(negedge clk);
        chk("l4_add_done", 32'({bus4.rf_we, bus4.in_ready}), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
